// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the core data-port store buffer: word addressing,
// FSM encoding and the layout of one buffered store.
package riscv_mem_pkg;

  // Byte offset bits below the word address; they take no part in matching.
  localparam int WORD_LSB = 2;

  // Default port widths of the riscv data port.
  localparam int WBUF_AW = 32;
  localparam int WBUF_DW = 32;

  // RUN: normal operation; FENCE: core held until every store has drained.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FENCE = 1'b1
  } wbuf_state_e;

  // One buffered store: word address plus data.
  typedef struct packed {
    logic [WBUF_AW-WORD_LSB-1:0] addr;
    logic [WBUF_DW-1:0]          data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_fwd_match.sv
// Youngest-match search over the valid region of the store buffer.
// Entries are visited oldest to youngest, so a later hit overrides an earlier
// one and the youngest matching store supplies the forwarded data.
module wbuf_fwd_match #(
  parameter int DEPTH = 4,
  parameter int TW    = 30,
  parameter int DW    = 32,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = PW + 1
) (
  input  logic [TW-1:0] addr_arr_i [DEPTH],
  input  logic [DW-1:0] data_arr_i [DEPTH],
  input  logic [PW-1:0] head_i,
  input  logic [CW-1:0] count_i,
  input  logic [TW-1:0] key_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);

  logic [PW-1:0] idx_s;

  // Walk the occupied slots from head; the youngest match wins.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx_s  = head_i;
    for (int i = 0; i < DEPTH; i++) begin
      idx_s = head_i + PW'(i);
      if ((CW'(i) < count_i) && (addr_arr_i[idx_s] == key_i)) begin
        hit_o  = 1'b1;
        data_o = data_arr_i[idx_s];
      end else begin
        hit_o  = hit_o;
        data_o = data_o;
      end
    end
  end

endmodule

// File: rtl/data_wbuf.sv
// Posted store buffer between the core data port and data_mem.
// Stores are queued and written back one per cycle whenever the memory port
// is not taken by a load miss; loads forward from the buffer on a word-address
// match; a fence holds the core until the buffer is empty.
module data_wbuf
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WBUF_AW,
  parameter int DW    = WBUF_DW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce_i,
  input  logic                   we_i,
  input  logic [AW-1:0]          addr_i,
  input  logic [DW-1:0]          wdata_i,
  input  logic                   fence_i,
  output logic [DW-1:0]          rdata_o,
  output logic                   stall_o,
  output logic                   mem_ce_o,
  output logic                   mem_we_o,
  output logic [AW-1:0]          mem_addr_o,
  output logic [DW-1:0]          mem_wdata_o,
  input  logic [DW-1:0]          mem_rdata_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = AW - WORD_LSB;

  wbuf_state_e   state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] ent_addr_q [DEPTH];
  logic [TW-1:0] ent_addr_d [DEPTH];
  logic [DW-1:0] ent_data_q [DEPTH];
  logic [DW-1:0] ent_data_d [DEPTH];

  logic          is_load_s;
  logic          is_store_s;
  logic          full_s;
  logic          nonempty_s;
  logic          fence_hold_s;
  logic          push_s;
  logic          pop_s;
  logic          fwd_hit_s;
  logic [DW-1:0] fwd_data_s;
  logic [TW-1:0] key_s;

  assign is_load_s    = ce_i & ~we_i;
  assign is_store_s   = ce_i & we_i;
  assign full_s       = (count_q == CW'(DEPTH));
  assign nonempty_s   = (count_q != CW'(0));
  assign fence_hold_s = fence_i & nonempty_s;
  assign key_s        = addr_i[AW-1:WORD_LSB];
  assign count_o      = count_q;
  assign empty_o      = (count_q == CW'(0));

  wbuf_fwd_match #(
    .DEPTH (DEPTH),
    .TW    (TW),
    .DW    (DW),
    .PW    (PW),
    .CW    (CW)
  ) u_fwd (
    .addr_arr_i (ent_addr_q),
    .data_arr_i (ent_data_q),
    .head_i     (head_q),
    .count_i    (count_q),
    .key_i      (key_s),
    .hit_o      (fwd_hit_s),
    .data_o     (fwd_data_s)
  );

  // FSM state register; reset returns to RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter FENCE while stores remain, leave once the last drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (fence_i && nonempty_s) begin
          state_d = ST_FENCE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FENCE: begin
        if ((count_q == CW'(1) && pop_s) || !nonempty_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FENCE;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // FSM outputs: memory port arbitration (load miss over drain), load data, stall.
  always_comb begin
    stall_o     = 1'b0;
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    rdata_o     = '0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (is_load_s && !fwd_hit_s) begin
          // Load miss owns the port; any drain waits a cycle.
          mem_ce_o   = 1'b1;
          mem_addr_o = addr_i;
          rdata_o    = mem_rdata_i;
        end else begin
          if (is_load_s) begin
            rdata_o = fwd_data_s;
          end else begin
            rdata_o = '0;
          end
          if (nonempty_s) begin
            pop_s       = 1'b1;
            mem_ce_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {ent_addr_q[head_q], {WORD_LSB{1'b0}}};
            mem_wdata_o = ent_data_q[head_q];
          end else begin
            pop_s = 1'b0;
          end
        end
        // A store stalls on a full buffer or behind a pending fence;
        // a stalled store leaves the port free so the head keeps draining.
        if (is_store_s && !full_s && !fence_hold_s) begin
          push_s = 1'b1;
        end else begin
          push_s = 1'b0;
        end
        stall_o = fence_hold_s | (is_store_s & full_s);
      end
      ST_FENCE: begin
        stall_o = 1'b1;
        if (nonempty_s) begin
          pop_s       = 1'b1;
          mem_ce_o    = 1'b1;
          mem_we_o    = 1'b1;
          mem_addr_o  = {ent_addr_q[head_q], {WORD_LSB{1'b0}}};
          mem_wdata_o = ent_data_q[head_q];
        end else begin
          pop_s = 1'b0;
        end
      end
      default: begin
        stall_o = 1'b0;
      end
    endcase
  end

  // FIFO next state: write at tail on push, advance head on pop.
  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    if (push_s) begin
      ent_addr_d[tail_q] = key_s;
      ent_data_d[tail_q] = wdata_i;
      tail_d             = tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    if (pop_s) begin
      head_d = head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
  end

  // FIFO registers; reset discards every queued store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
    end
  end

endmodule
